pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Program-counter stage of the RISC-V core; holds the architectural PC and computes the next PC.
- Directly consumes the ALU outputs:
  - `zero` is the branch-condition flag (beq/bne/blt/bge result).
  - `data_out` is the jalr target.
- Feeds the instruction-memory address and the pc+4 link value for jal/jalr writeback.
- Adds three features over a bare PC register: stall hold, a sticky misaligned-target trap, and a retired-instruction counter.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- CNT_WIDTH, 32, width of retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and counter this cycle.
- branch  input  1  current instruction is a conditional branch.
- jal  input  1  current instruction is jal.
- jalr  input  1  current instruction is jalr.
- zero  input  1  ALU branch-condition flag; 1 = condition true.
- alu_result  input  32  ALU data_out; jalr target before LSB clear.
- imm  input  32  sign-extended immediate, already shifted (B/J offset).
- pc  output  32  current PC (registered).
- pc_plus4  output  32  pc + 4, combinational, for rd link writeback.
- redirect  output  1  combinational; 1 when a taken jump/branch selects a non-sequential target.
- misaligned  output  1  sticky trap flag (registered).
- instret  output  CNT_WIDTH  retired-instruction count (registered).

Behaviour:
- Reset (rst=1 at posedge), regardless of all other inputs:
  - pc <= RESET_VECTOR.
  - misaligned <= 0.
  - instret <= 0.
  - Reset during stall or during a trap behaves identically.
- Target select, combinational, fixed priority:
  - jalr: target = alu_result & 32'hFFFF_FFFE; redirect=1.
  - else jal: target = pc + imm; redirect=1.
  - else branch & zero: target = pc + imm; redirect=1.
  - else: target = pc_plus4; redirect=0.
  - Multiple of jalr/jal/branch asserted simultaneously: priority above applies, no error.
- Arithmetic:
  - All adds are 32-bit modulo 2^32.
  - pc = 32'hFFFF_FFFC gives pc_plus4 = 0.
  - pc + negative imm wraps likewise.
- Misalignment check: bad = redirect & (target[1:0] != 2'b00).
- Sequential update at posedge with rst=0:
  - misaligned=1: hold pc and instret; the trap state is left only via reset.
  - else stall=1: hold pc and instret; misalignment not evaluated; no flag set.
  - else bad=1: misaligned <= 1; pc holds (pc stays at the faulting instruction); instret unchanged.
  - else: pc <= target; instret <= instret + 1 (wraps at 2^CNT_WIDTH).
- Latency:
  - pc changes one cycle after inputs are sampled.
  - redirect and pc_plus4 respond in the same cycle to pc and the input signals.
- redirect is driven even while stalled or trapped (pure function of inputs); consumers qualify it with stall/misaligned.
- States: RUN (misaligned=0) and TRAP (misaligned=1).
  - RUN->TRAP on bad & ~stall.
  - TRAP->RUN only on rst.

Test Plan:
- Reset then 3 free-running cycles, no control inputs -> pc 0x0,0x4,0x8,0xC; instret 3; pc_plus4 = pc+4 each cycle.
- pc=0x100, branch=1, zero=1, imm=-8 -> next pc 0xF8, redirect=1. Same with zero=0 -> next pc 0x104, redirect=0.
- jalr=1, jal=1, alu_result=0x2001 -> next pc 0x2000 (jalr wins, LSB cleared); pc_plus4 before the edge = old pc+4.
- pc=0x40, jal=1, imm=0x6 -> misaligned=1, pc stays 0x40, instret frozen. Further cycles with valid inputs -> pc stays 0x40. Then rst -> pc=RESET_VECTOR, misaligned=0.
- stall=1 for 2 cycles with jal=1, imm=0x2 -> pc and instret unchanged, misaligned stays 0. Stall released -> trap sets.
- pc=0xFFFF_FFFC, no control -> pc wraps to 0x0. Separately, instret preloaded near max with CNT_WIDTH=4: 15 -> 0 after one retire.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program-counter stage of the RISC-V core.
// It holds the architectural PC and picks the next PC from the jalr, jal, branch
// or sequential path. It also provides stall hold, a sticky misaligned-target
// trap and a retired-instruction counter.
//
// Flow control: stall is the only handshake input. When stall=1 at a rising
// edge, pc and instret keep their values and no trap can be raised in that
// cycle. redirect is a pure function of pc and the control inputs. It is driven
// even while stalled or trapped, so consumers must qualify it with stall and
// misaligned.
module pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 branch,
    input  logic                 jal,
    input  logic                 jalr,
    input  logic                 zero,
    input  logic [31:0]          alu_result,
    input  logic [31:0]          imm,
    output logic [31:0]          pc,
    output logic [31:0]          pc_plus4,
    output logic                 redirect,
    output logic                 misaligned,
    output logic [CNT_WIDTH-1:0] instret
);

    // RUN: normal fetch. TRAP: a misaligned target was taken; only reset leaves it.
    // The state is exposed directly on the misaligned output.
    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] target;
    logic        bad;
    logic        retire;

    assign pc_plus4   = pc + 32'd4;
    assign misaligned = (state == TRAP);

    // Next-PC target select: jalr beats jal, and jal beats a taken branch.
    always_comb begin
        target   = pc_plus4;
        redirect = 1'b0;
        if (jalr) begin
            target   = alu_result & 32'hFFFF_FFFE;
            redirect = 1'b1;
        end else if (jal) begin
            target   = pc + imm;
            redirect = 1'b1;
        end else if (branch && zero) begin
            target   = pc + imm;
            redirect = 1'b1;
        end
    end

    assign bad = redirect && (target[1:0] != 2'b00);

    // Next state and retire decision.
    // A stalled cycle never evaluates misalignment.
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            RUN: begin
                if (!stall) begin
                    if (bad) begin
                        state_next = TRAP;
                    end else begin
                        retire = 1'b1;
                    end
                end
            end
            TRAP: begin
                state_next = TRAP;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // State register; reset always returns to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // PC and retired-count registers advance only when an instruction retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_VECTOR;
            instret <= '0;
        end else if (retire) begin
            pc      <= target;
            instret <= instret + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed test of pc_unit.
// The driver applies one vector per cycle and pushes the hand-computed response
// into exp_q. A monitor on the falling edge pops and compares. A second instance
// with CNT_WIDTH=4 shares the same inputs to cover counter wrap.
module tb_pc_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        redirect;
        logic        mis;
        logic [31:0] ir;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] imm;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic        misaligned;
    logic [31:0] instret;

    logic [31:0] pc_n4;
    logic [31:0] pc_plus4_n4;
    logic        redirect_n4;
    logic        misaligned_n4;
    logic [3:0]  instret_n4;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    pc_unit #(.RESET_VECTOR(32'h0), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .jal(jal),
        .jalr(jalr), .zero(zero), .alu_result(alu_result), .imm(imm),
        .pc(pc), .pc_plus4(pc_plus4), .redirect(redirect),
        .misaligned(misaligned), .instret(instret)
    );

    pc_unit #(.RESET_VECTOR(32'h0), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .jal(jal),
        .jalr(jalr), .zero(zero), .alu_result(alu_result), .imm(imm),
        .pc(pc_n4), .pc_plus4(pc_plus4_n4), .redirect(redirect_n4),
        .misaligned(misaligned_n4), .instret(instret_n4)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one field and count the result.
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
        end
    endtask

    // Monitor: on each falling edge with a pending expectation, compare the DUT outputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("pc", pc, e.pc);
            check("pc_plus4", pc_plus4, e.pc_plus4);
            check("redirect", {31'b0, redirect}, {31'b0, e.redirect});
            check("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
            check("instret", instret, e.ir);
            check("instret_w4", {28'b0, instret_n4}, {28'b0, e.ir[3:0]});
        end
    end

    // Driver: apply one cycle of inputs and queue the expected response before the next edge.
    task automatic step(input logic r, input logic s, input logic b, input logic j,
                        input logic jr, input logic z, input logic [31:0] alu,
                        input logic [31:0] im, input logic [31:0] e_pc,
                        input logic e_red, input logic e_mis, input logic [31:0] e_ir);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; stall = s; branch = b; jal = j; jalr = jr; zero = z;
        alu_result = alu; imm = im;
        e.pc = e_pc; e.pc_plus4 = e_pc + 32'd4; e.redirect = e_red; e.mis = e_mis; e.ir = e_ir;
        exp_q.push_back(e);
    endtask

    initial begin
        int wait_cycles;
        checks = 0; failures = 0;
        rst = 1'b1; stall = 1'b0; branch = 1'b0; jal = 1'b0; jalr = 1'b0; zero = 1'b0;
        alu_result = 32'h0; imm = 32'h0;
        repeat (2) @(posedge clk);

        //    rst s  b  j  jr z  alu           imm           exp_pc        red mis ir
        // Free run after reset
        step(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0000, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0004, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0008, 0, 0, 2);
        step(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_000C, 0, 0, 3);
        // jal to 0x100
        step(0, 0, 0, 1, 0, 0, 32'h0,        32'h0000_00F0, 32'h0000_0010, 1, 0, 4);
        // Taken branch backwards by 8
        step(0, 0, 1, 0, 0, 1, 32'h0,        32'hFFFF_FFF8, 32'h0000_0100, 1, 0, 5);
        step(0, 0, 0, 1, 0, 0, 32'h0,        32'h0000_0008, 32'h0000_00F8, 1, 0, 6);
        // Not-taken branch
        step(0, 0, 1, 0, 0, 0, 32'h0,        32'hFFFF_FFF8, 32'h0000_0100, 0, 0, 7);
        // jalr and jal together: jalr wins with LSB cleared
        step(0, 0, 0, 1, 1, 0, 32'h0000_2001, 32'h0000_0040, 32'h0000_0104, 1, 0, 8);
        step(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h0,        32'h0000_2000, 1, 0, 9);
        // Wrap from 0xFFFF_FFFC
        step(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'hFFFF_FFFC, 0, 0, 10);
        step(0, 0, 0, 1, 0, 0, 32'h0,        32'h0000_0040, 32'h0000_0000, 1, 0, 11);
        // Misaligned jal from 0x40 traps; trap persists
        step(0, 0, 0, 1, 0, 0, 32'h0,        32'h0000_0006, 32'h0000_0040, 1, 0, 12);
        step(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0040, 0, 1, 12);
        step(0, 0, 0, 1, 0, 0, 32'h0,        32'h0000_0008, 32'h0000_0040, 1, 1, 12);
        // Reset out of trap
        step(1, 0, 0, 1, 0, 0, 32'h0,        32'h0000_0008, 32'h0000_0040, 1, 1, 12);
        // Stall masks a misaligned jal, then release traps
        step(0, 1, 0, 1, 0, 0, 32'h0,        32'h0000_0002, 32'h0000_0000, 1, 0, 0);
        step(0, 1, 0, 1, 0, 0, 32'h0,        32'h0000_0002, 32'h0000_0000, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0, 32'h0,        32'h0000_0002, 32'h0000_0000, 1, 0, 0);
        // Reset while stalled and trapped
        step(1, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0000, 0, 1, 0);
        // Free run of 17 cycles; the 4-bit counter wraps 15 -> 0
        for (int k = 0; k <= 16; k++) begin
            step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'(4 * k), 0, 0, 32'(k));
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
